// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler.
// Owns the single write port of the predictor tables. Resolved branches from EX
// are buffered in a small FIFO and written one per cycle. A flush request
// discards the buffered updates and sweeps every table entry invalid while
// prediction is blocked.
module bp_update_sched #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ENTRY_NUM     = 256,
  parameter int PR_ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     upd_valid,
  input  logic [ADDR_WIDTH-1:0]    upd_pc,
  input  logic [ADDR_WIDTH-1:0]    upd_target,
  input  logic                     upd_taken,
  input  logic                     upd_is_loop,
  output logic                     upd_ready,
  input  logic                     flush_req,
  output logic                     tbl_wen,
  output logic                     tbl_wclr,
  output logic [PR_ADDR_WIDTH-1:0] tbl_waddr,
  output logic [ADDR_WIDTH-1:0]    tbl_wpc,
  output logic [ADDR_WIDTH-1:0]    tbl_wtarget,
  output logic                     tbl_wtaken,
  output logic                     tbl_wloop,
  output logic                     predict_block,
  output logic                     flush_done,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 * ADDR_WIDTH + 2;
  localparam int IDX_W = PR_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   fifo_count, count_after;
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head_entry;
  logic             fifo_empty, fifo_full;

  // Sweep index has an extra MSB; it is set once every entry has been issued.
  logic [IDX_W-1:0] sweep_idx_reg;

  logic                     push, pop, flush_start, sweep_active;
  logic [ADDR_WIDTH-1:0]    head_pc, head_target;
  logic                     head_taken, head_loop;

  logic                     tbl_wen_reg, tbl_wclr_reg;
  logic [PR_ADDR_WIDTH-1:0] tbl_waddr_reg;
  logic [ADDR_WIDTH-1:0]    tbl_wpc_reg, tbl_wtarget_reg;
  logic                     tbl_wtaken_reg, tbl_wloop_reg;
  logic                     predict_block_reg, flush_done_reg;
  logic [15:0]              drop_cnt_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;

  // A flush request in IDLE/DRAIN starts the sweep; in FLUSH it is ignored.
  assign flush_start = flush_req && (state_reg != FLUSH);

  // The update arriving with a flush request is stale and must not be taken.
  assign upd_ready    = !fifo_full && (state_reg != FLUSH) && !flush_req;
  assign push         = upd_valid && upd_ready;
  assign pop          = !fifo_empty && (state_reg != FLUSH) && !flush_req;
  assign sweep_active = (state_reg == FLUSH) && !sweep_idx_reg[IDX_W-1];

  assign count_after = fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  assign head_entry = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign {head_pc, head_target, head_taken, head_loop} = head_entry;

  // Update buffer storage; contents need no reset since pointers gate reads.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {upd_pc, upd_target, upd_taken, upd_is_loop};
    end
  end

  // FIFO pointers: cleared together when a flush starts.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush_start) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_W + 1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W + 1)'(1);
    end
  end

  // State register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: DRAIN while anything remains buffered, FLUSH until swept.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DRAIN: begin
        if (flush_req)               state_next = FLUSH;
        else if (count_after != '0)  state_next = DRAIN;
        else                         state_next = IDLE;
      end
      FLUSH: begin
        if (sweep_idx_reg[IDX_W-1])  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep index: entry 0 is issued in the flush-start cycle, the rest in FLUSH.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sweep_idx_reg <= '0;
    end else if (flush_start) begin
      sweep_idx_reg <= IDX_W'(1);
    end else if (sweep_active) begin
      sweep_idx_reg <= sweep_idx_reg + IDX_W'(1);
    end else if (state_reg == FLUSH) begin
      sweep_idx_reg <= '0;
    end
  end

  // Table write port: sweep writes take priority over buffered updates.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      tbl_wen_reg     <= 1'b0;
      tbl_wclr_reg    <= 1'b0;
      tbl_waddr_reg   <= '0;
      tbl_wpc_reg     <= '0;
      tbl_wtarget_reg <= '0;
      tbl_wtaken_reg  <= 1'b0;
      tbl_wloop_reg   <= 1'b0;
    end else begin
      tbl_wen_reg  <= 1'b0;
      tbl_wclr_reg <= 1'b0;
      if (flush_start || sweep_active) begin
        tbl_wen_reg     <= 1'b1;
        tbl_wclr_reg    <= 1'b1;
        tbl_waddr_reg   <= flush_start ? '0 : sweep_idx_reg[PR_ADDR_WIDTH-1:0];
        tbl_wpc_reg     <= '0;
        tbl_wtarget_reg <= '0;
        tbl_wtaken_reg  <= 1'b0;
        tbl_wloop_reg   <= 1'b0;
      end else if (pop) begin
        tbl_wen_reg     <= 1'b1;
        tbl_waddr_reg   <= head_pc[PR_ADDR_WIDTH+1:2];
        tbl_wpc_reg     <= head_pc;
        tbl_wtarget_reg <= head_target;
        tbl_wtaken_reg  <= head_taken;
        tbl_wloop_reg   <= head_loop;
      end
    end
  end

  // Prediction blocking and end-of-sweep pulse follow the FSM one cycle later.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      predict_block_reg <= 1'b0;
      flush_done_reg    <= 1'b0;
    end else begin
      predict_block_reg <= (state_next == FLUSH);
      flush_done_reg    <= (state_reg == FLUSH) && (state_next == IDLE);
    end
  end

  // Lost-update counter, saturating at all ones.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      drop_cnt_reg <= '0;
    end else if (upd_valid && !upd_ready && (drop_cnt_reg != 16'hffff)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign tbl_wen       = tbl_wen_reg;
  assign tbl_wclr      = tbl_wclr_reg;
  assign tbl_waddr     = tbl_waddr_reg;
  assign tbl_wpc       = tbl_wpc_reg;
  assign tbl_wtarget   = tbl_wtarget_reg;
  assign tbl_wtaken    = tbl_wtaken_reg;
  assign tbl_wloop     = tbl_wloop_reg;
  assign predict_block = predict_block_reg;
  assign flush_done    = flush_done_reg;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_bp_update_sched.sv
// Testbench for bp_update_sched: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bp_update_sched;

  localparam int AW  = 32;
  localparam int EN  = 256;
  localparam int PW  = 8;
  localparam int FD  = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic [AW-1:0] upd_target = '0;
  logic          upd_taken = 1'b0;
  logic          upd_is_loop = 1'b0;
  logic          upd_ready;
  logic          flush_req = 1'b0;
  logic          tbl_wen;
  logic          tbl_wclr;
  logic [PW-1:0] tbl_waddr;
  logic [AW-1:0] tbl_wpc;
  logic [AW-1:0] tbl_wtarget;
  logic          tbl_wtaken;
  logic          tbl_wloop;
  logic          predict_block;
  logic          flush_done;
  logic [15:0]   drop_cnt;

  bp_update_sched #(
    .ADDR_WIDTH(AW), .ENTRY_NUM(EN), .PR_ADDR_WIDTH(PW), .FIFO_DEPTH(FD)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_loop(upd_is_loop), .upd_ready(upd_ready),
    .flush_req(flush_req),
    .tbl_wen(tbl_wen), .tbl_wclr(tbl_wclr), .tbl_waddr(tbl_waddr),
    .tbl_wpc(tbl_wpc), .tbl_wtarget(tbl_wtarget), .tbl_wtaken(tbl_wtaken),
    .tbl_wloop(tbl_wloop), .predict_block(predict_block),
    .flush_done(flush_done), .drop_cnt(drop_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    logic          tk;
    logic          lp;
  } ent_t;

  ent_t          q[$];
  bit            m_flushing = 0;
  int            m_sweep = 0;
  logic          m_wen = 0, m_wclr = 0, m_wtk = 0, m_wlp = 0, m_pb = 0, m_done = 0;
  logic [PW-1:0] m_waddr = '0;
  logic [AW-1:0] m_wpc = '0, m_wtgt = '0;
  int            m_drop = 0;

  function automatic bit m_ready();
    return !m_flushing && (q.size() < FD) && !flush_req;
  endfunction

  task automatic m_sweep_write(input int idx);
    m_wen = 1; m_wclr = 1; m_waddr = PW'(idx);
    m_wpc = '0; m_wtgt = '0; m_wtk = 0; m_wlp = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   rdy;
    if (cpu_rst) begin
      q.delete();
      m_flushing = 0; m_sweep = 0;
      m_wen = 0; m_wclr = 0; m_waddr = '0; m_wpc = '0; m_wtgt = '0;
      m_wtk = 0; m_wlp = 0; m_pb = 0; m_done = 0; m_drop = 0;
      return;
    end
    rdy = m_ready();
    m_wen = 0; m_wclr = 0; m_done = 0;
    if (upd_valid && !rdy && m_drop < 65535) m_drop++;
    if (!m_flushing) begin
      if (flush_req) begin
        q.delete();
        m_flushing = 1;
        m_sweep_write(0);
        m_sweep = 1;
      end else begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_wen = 1; m_waddr = e.pc[PW+1:2];
          m_wpc = e.pc; m_wtgt = e.tgt; m_wtk = e.tk; m_wlp = e.lp;
        end
        if (upd_valid && rdy) begin
          e.pc = upd_pc; e.tgt = upd_target; e.tk = upd_taken; e.lp = upd_is_loop;
          q.push_back(e);
        end
      end
    end else if (m_sweep < EN) begin
      m_sweep_write(m_sweep);
      m_sweep++;
    end else begin
      m_flushing = 0;
      m_done = 1;
    end
    m_pb = m_flushing;
  endtask

  initial forever begin
    @(posedge cpu_clk or posedge cpu_rst);
    model_step();
  end

  // Compare process: every falling edge once the design is out of its first reset.
  initial begin
    wait (cmp_en);
    forever begin
      @(negedge cpu_clk);
      chk("upd_ready", 32'(upd_ready), 32'(m_ready()));
      chk("tbl_wen", 32'(tbl_wen), 32'(m_wen));
      chk("tbl_wclr", 32'(tbl_wclr), 32'(m_wclr));
      chk("tbl_waddr", 32'(tbl_waddr), 32'(m_waddr));
      chk("tbl_wpc", tbl_wpc, m_wpc);
      chk("tbl_wtarget", tbl_wtarget, m_wtgt);
      chk("tbl_wtaken", 32'(tbl_wtaken), 32'(m_wtk));
      chk("tbl_wloop", 32'(tbl_wloop), 32'(m_wlp));
      chk("predict_block", 32'(predict_block), 32'(m_pb));
      chk("flush_done", 32'(flush_done), 32'(m_done));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic single_update_check(input string tag);
    upd_valid = 1; upd_pc = 32'h0000_0108; upd_target = 32'h0000_2000;
    upd_taken = 1; upd_is_loop = 0;
    tick();
    upd_valid = 0;
    tick();
    chk({tag, "_wen"}, 32'(tbl_wen), 32'd1);
    chk({tag, "_wclr"}, 32'(tbl_wclr), 32'd0);
    chk({tag, "_waddr"}, 32'(tbl_waddr), 32'h42);
    chk({tag, "_wpc"}, tbl_wpc, 32'h108);
    chk({tag, "_wtaken"}, 32'(tbl_wtaken), 32'd1);
    tick();
    chk({tag, "_wen_after"}, 32'(tbl_wen), 32'd0);
  endtask

  int sw_ok, pb_n, done_n;

  initial begin
    cpu_rst = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #3 cpu_rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    chk("rst_upd_ready", 32'(upd_ready), 32'd1);
    chk("rst_tbl_wen", 32'(tbl_wen), 32'd0);
    chk("rst_predict_block", 32'(predict_block), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Single update latency.
    single_update_check("single");

    // Six back-to-back updates drain in order.
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1; upd_pc = 32'h1000 + 32'(4 * i); upd_target = 32'h8000 + 32'(i);
      upd_taken = i[0]; upd_is_loop = i[1];
      tick();
    end
    upd_valid = 0;
    chk("b2b_wpc4", tbl_wpc, 32'h1010);
    tick();
    chk("b2b_wen5", 32'(tbl_wen), 32'd1);
    chk("b2b_wpc5", tbl_wpc, 32'h1014);
    tick();
    chk("b2b_wen_end", 32'(tbl_wen), 32'd0);
    chk("b2b_drop", 32'(drop_cnt), 32'd0);

    // Flush sweep with updates arriving throughout and a second flush request.
    flush_req = 1; upd_valid = 0;
    tick();
    sw_ok = 0; pb_n = 0; done_n = 0;
    for (int s = 1; s <= 258; s++) begin
      if (s <= 256 && tbl_wen && tbl_wclr && tbl_waddr == PW'(s - 1)) sw_ok++;
      if (predict_block) pb_n++;
      if (flush_done) done_n++;
      flush_req = (s == 101);
      upd_valid = (s <= 256);
      upd_pc = $urandom;
      tick();
    end
    upd_valid = 0; flush_req = 0;
    chk("flush_sweep_writes", 32'(sw_ok), 32'd256);
    chk("flush_pb_cycles", 32'(pb_n), 32'd256);
    chk("flush_done_pulses", 32'(done_n), 32'd1);
    chk("flush_drop_cnt", 32'(drop_cnt), 32'd256);

    // Asynchronous reset in the middle of a sweep.
    flush_req = 1;
    tick();
    flush_req = 0;
    repeat (17) tick();
    chk("mid_sweep_waddr", 32'(tbl_waddr), 32'd17);
    #2 cpu_rst = 1'b1;
    #1;
    chk("arst_wen", 32'(tbl_wen), 32'd0);
    chk("arst_wclr", 32'(tbl_wclr), 32'd0);
    chk("arst_pb", 32'(predict_block), 32'd0);
    chk("arst_waddr", 32'(tbl_waddr), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    #2 cpu_rst = 1'b0;
    tick();
    single_update_check("post_rst");

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      upd_valid   = ($urandom_range(0, 9) < 7);
      flush_req   = ($urandom_range(0, 199) == 0);
      upd_pc      = $urandom;
      upd_target  = $urandom;
      upd_taken   = 1'($urandom_range(0, 1));
      upd_is_loop = 1'($urandom_range(0, 1));
      tick();
    end

    // Saturation: every cycle drops.
    upd_valid = 1; flush_req = 1;
    repeat (66000) tick();
    chk("drop_saturated", 32'(drop_cnt), 32'h0000_ffff);
    upd_valid = 0; flush_req = 0;
    repeat (300) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
